// File: rtl/mem_arbiter.sv
// Shares one fixed-latency unified memory between the fetch port and the data port.
// Data wins by default; a pending fetch is forced ahead after MAX_WAIT consecutive data grants.
//
// state | meaning
// IDLE  | no access in flight; arbitrate pending requests
// ISSUE | mem_en strobe to the memory
// WAIT  | count down the read latency, capture read data on the last cycle
// RESP  | one-cycle ready pulse to the owner; requests ignored
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LAT      = 2,
    parameter int MAX_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam int LW = $clog2(LAT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
    localparam logic [LW-1:0] LAT_LOAD   = LW'(LAT);
    localparam logic [LW-1:0] LAT_LAST   = LW'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [LW-1:0]   lat_cnt;
    logic [SW-1:0]   starve_cnt;
    logic            grant_any;
    logic            grant_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_any = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_any = 1'b1;
                    // a starved fetch overrides the default data priority
                    grant_d   = d_req && !(i_req && (starve_cnt == STARVE_MAX));
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            if (grant_any) begin
                owner    <= grant_d;
                mem_addr <= grant_d ? d_addr : i_addr;
                mem_we   <= grant_d && d_we;
                if (grant_d) begin
                    mem_wdata <= d_wdata;
                end
                if (!grant_d) begin
                    starve_cnt <= '0;
                end else if (i_req && (starve_cnt != STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end

            if (state == ISSUE) begin
                lat_cnt <= LAT_LOAD;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 1'b1;
            end

            if ((state == WAIT) && (lat_cnt == LAT_LAST) && !mem_we) begin
                if (owner) begin
                    d_rdata <= mem_rdata;
                end else begin
                    i_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_en  = (state == ISSUE);
    assign busy    = (state != IDLE);
    assign i_ready = (state == RESP) && !owner;
    assign d_ready = (state == RESP) && owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic checked cycle by cycle
// against a transaction-level model of grants, latencies and memory contents.
module tb_mem_arbiter;

    localparam int LAT      = 2;
    localparam int MAX_WAIT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_ready, d_ready, mem_en, mem_we, busy, owner;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    logic        x_i_req, x_d_req, x_d_we;
    logic [31:0] x_i_addr, x_d_addr, x_d_wdata, x_mem_rdata;
    logic        x_i_ready, x_d_ready, x_mem_en, x_mem_we, x_busy, x_owner;
    logic [31:0] x_i_rdata, x_d_rdata, x_mem_addr, x_mem_wdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1), .MAX_WAIT(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .i_req(x_i_req), .i_addr(x_i_addr), .i_ready(x_i_ready), .i_rdata(x_i_rdata),
        .d_req(x_d_req), .d_we(x_d_we), .d_addr(x_d_addr), .d_wdata(x_d_wdata),
        .d_ready(x_d_ready), .d_rdata(x_d_rdata),
        .mem_en(x_mem_en), .mem_we(x_mem_we), .mem_addr(x_mem_addr), .mem_wdata(x_mem_wdata),
        .mem_rdata(x_mem_rdata), .busy(x_busy), .owner(x_owner)
    );

    int errors = 0;
    int checks = 0;

    // transaction-level model state
    int          k = 0;
    int          en_cyc = -1, rdy_cyc = -1, free_at = 0;
    int          starve = 0;
    bit          cur_own, cur_we, own_exp, we_exp;
    logic [31:0] cur_addr, cur_wdata, cur_rdata, addr_exp;
    logic [31:0] i_rdata_exp = '0, d_rdata_exp = '0;
    logic [31:0] mem_model [16];

    // requester state
    bit          gen = 1'b0;
    int          p_i = 0, p_d = 0;
    bit          i_act = 1'b0, d_act = 1'b0, i_rel = 1'b0, d_rel = 1'b0, dwe = 1'b0;
    logic [31:0] ia = '0, da = '0, dw = '0;

    bit          dut_grants [$];
    int          dut_en [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_i_ready"}, i_ready, 0);
        chk({tag, "_d_ready"}, d_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_owner"}, owner, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_i_rdata"}, i_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
        chk({tag, "_l1_busy"}, x_busy, 0);
        chk({tag, "_l1_vals"}, {x_i_rdata[7:0], x_d_rdata[7:0], x_mem_addr[7:0], x_mem_wdata[7:0]}, 0);
        chk({tag, "_l1_bits"}, {x_mem_we, x_owner, x_mem_en, x_i_ready, x_d_ready}, 0);
    endtask

    // one clock cycle: check outputs of cycle k, then drive inputs and apply model grants
    task automatic step();
        bit gd;
        @(negedge clk);
        k++;
        if (k == rdy_cyc && !cur_we) begin
            if (cur_own) d_rdata_exp = cur_rdata;
            else         i_rdata_exp = cur_rdata;
        end
        chk("mem_en", mem_en, k == en_cyc);
        chk("busy", busy, en_cyc >= 0 && k >= en_cyc && k <= rdy_cyc);
        chk("i_ready", i_ready, k == rdy_cyc && !cur_own);
        chk("d_ready", d_ready, k == rdy_cyc && cur_own);
        chk("owner", owner, own_exp);
        chk("mem_addr", mem_addr, addr_exp);
        chk("mem_we", mem_we, we_exp);
        if (k == en_cyc && cur_we) chk("mem_wdata", mem_wdata, cur_wdata);
        chk("i_rdata", i_rdata, i_rdata_exp);
        chk("d_rdata", d_rdata, d_rdata_exp);
        if (mem_en) begin
            dut_grants.push_back(owner);
            dut_en.push_back(k);
        end

        // memory returns valid data only in the cycle it is due
        mem_rdata = (en_cyc >= 0 && k == en_cyc + LAT && !cur_we) ? cur_rdata : $urandom;

        if (i_rel) begin i_act = 1'b0; i_rel = 1'b0; end
        if (d_rel) begin d_act = 1'b0; d_rel = 1'b0; end
        if (k == rdy_cyc) begin
            if (cur_own) d_rel = 1'b1;
            else         i_rel = 1'b1;
        end
        if (gen && !i_act && $urandom_range(99) < p_i) begin
            i_act = 1'b1; ia = $urandom;
        end
        if (gen && !d_act && $urandom_range(99) < p_d) begin
            d_act = 1'b1; da = $urandom; dw = $urandom; dwe = $urandom_range(1);
        end
        i_req = i_act; i_addr = ia;
        d_req = d_act; d_addr = da; d_wdata = dw; d_we = dwe;

        if (k >= free_at && (i_act || d_act)) begin
            gd = d_act && !(i_act && starve == MAX_WAIT);
            if (!gd) starve = 0;
            else if (i_act && starve < MAX_WAIT) starve++;
            cur_own   = gd;
            cur_we    = gd && dwe;
            cur_addr  = gd ? da : ia;
            cur_wdata = dw;
            en_cyc    = k + 1;
            rdy_cyc   = k + LAT + 2;
            free_at   = k + LAT + 3;
            own_exp   = gd;
            addr_exp  = cur_addr;
            we_exp    = cur_we;
            if (cur_we) mem_model[cur_addr[5:2]] = dw;
            else        cur_rdata = mem_model[cur_addr[5:2]];
        end
    endtask

    task automatic drain();
        int n = 0;
        gen = 1'b0;
        while ((i_act || d_act || k < free_at) && n < 60) begin
            step();
            n++;
        end
        chk("drain_done", n < 60, 1);
    endtask

    initial begin
        int n;
        int ord [6] = '{1, 1, 0, 1, 1, 0};

        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
        mem_model[4] = 32'hDEADBEEF;
        reset = 1'b1;
        {i_req, d_req, d_we} = '0;
        {i_addr, d_addr, d_wdata, mem_rdata} = '0;
        {x_i_req, x_d_req, x_d_we} = '0;
        {x_i_addr, x_d_addr, x_d_wdata, x_mem_rdata} = '0;
        addr_exp = '0;
        repeat (2) @(posedge clk);
        #1 chk_rst("reset");
        #1 reset = 1'b0;

        // LAT=1 corner: data read, memory data valid only in cycle 2
        @(negedge clk);
        x_d_req = 1'b1; x_d_we = 1'b0; x_d_addr = 32'h40; x_mem_rdata = 32'h0BADF00D;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("l1_mem_en", x_mem_en, c == 1);
            chk("l1_d_ready", x_d_ready, c == 3);
            chk("l1_i_ready", x_i_ready, 0);
            if (c == 1) chk("l1_mem_addr", x_mem_addr, 32'h40);
            if (c == 3) chk("l1_d_rdata", x_d_rdata, 32'hC0FFEE01);
            x_mem_rdata = (c == 2) ? 32'hC0FFEE01 : 32'h0BADF00D + c;
            if (c == 4) x_d_req = 1'b0;
        end

        // single fetch from 0x10
        i_act = 1'b1; ia = 32'h10;
        drain();
        chk("fetch_word", i_rdata, 32'hDEADBEEF);

        // data write to 0x20 leaves d_rdata alone
        d_act = 1'b1; da = 32'h20; dw = 32'h12345678; dwe = 1'b1;
        drain();
        chk("write_keeps_d_rdata", d_rdata, 0);

        // both ports held: fetch forced ahead every third grant
        dut_grants.delete();
        p_i = 100; p_d = 100; gen = 1'b1;
        n = 0;
        while (dut_grants.size() < 6 && n < 100) begin step(); n++; end
        chk("starve_grants_seen", n < 100, 1);
        drain();
        for (int i = 0; i < 6; i++) chk($sformatf("grant_order%0d", i), dut_grants[i], ord[i]);

        // data request raised while a fetch is in WAIT
        dut_en.delete();
        i_act = 1'b1; ia = $urandom;
        n = 0;
        while (!(en_cyc >= 0 && k == en_cyc + 1) && n < 20) begin step(); n++; end
        d_act = 1'b1; da = $urandom; dw = $urandom; dwe = $urandom_range(1);
        drain();
        chk("busy_req_grants", dut_en.size(), 2);
        if (dut_en.size() >= 2) chk("busy_req_gap", dut_en[1] - dut_en[0], LAT + 3);

        // random traffic
        p_i = 40; p_d = 50; gen = 1'b1;
        repeat (400) step();
        drain();

        // reset in the middle of a fetch's WAIT, fetch request kept high
        i_act = 1'b1; ia = $urandom;
        n = 0;
        while (!(en_cyc >= 0 && k == en_cyc + 1) && n < 20) begin step(); n++; end
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_rst("midreset");
        @(negedge clk);
        k++;
        chk_rst("midreset_hold");
        @(posedge clk);
        #2 reset = 1'b0;
        en_cyc = -1; rdy_cyc = -1; free_at = 0; starve = 0;
        own_exp = 1'b0; we_exp = 1'b0; addr_exp = '0; cur_own = 1'b0; cur_we = 1'b0;
        i_rdata_exp = '0; d_rdata_exp = '0; i_rel = 1'b0;
        dut_en.delete();
        drain();
        chk("post_reset_reissue", dut_en.size(), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
